// File: rtl/pc_if_pkg.sv
// pc_if shared types: fetch FSM states, boot address,
// NOP encoding and stall-vector bit positions.
package pc_if_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_ERR
  } if_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_IF  = 0;
  localparam int unsigned STALL_ID  = 1;
  localparam int unsigned STALL_EX  = 2;
  localparam int unsigned STALL_MEM = 3;
  localparam int unsigned STALL_WB  = 4;
  localparam int unsigned STALL_CP  = 5;

  // IF holds when it or the ID register behind it is held
  localparam logic [STALL_W-1:0] IF_HOLD_MASK =
    STALL_W'((1 << STALL_IF) | (1 << STALL_ID));

endpackage

// File: rtl/pc_if.sv
// Instruction-fetch stage: pc register, single-outstanding
// imem handshake, delayed-branch redirect and flush handling.
module pc_if
  import pc_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               branch_flag,
  input  logic [31:0]        branch_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_pc,
  output logic [31:0]        pc_inst,
  output logic               stallreq_if,
  output logic               pc_adel
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic        aligned;
  logic        stall_if;
  logic        ack_v;
  logic        complete;
  logic [31:0] next_pc;

  assign aligned  = (pc_q[1:0] == 2'b00);
  assign stall_if = |(stall & IF_HOLD_MASK);

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    pc_inst     = NOP_INST;
    stallreq_if = 1'b0;
    pc_adel     = 1'b0;
    pc_pc       = pc_q;
    unique case (state_q)
      S_WAIT: begin
        imem_req = aligned;
        if (aligned && imem_ack) begin
          pc_inst = imem_rdata;
        end else begin
          stallreq_if = 1'b1;
        end
      end
      S_HOLD: pc_inst = inst_buf_q;
      S_DROP: begin
        // keep the abandoned request stable until memory acks
        imem_req    = 1'b1;
        imem_addr   = req_addr_q;
        stallreq_if = 1'b1;
      end
      S_ERR:  pc_adel = 1'b1;
      default: ;
    endcase
  end

  assign ack_v    = imem_req & imem_ack;
  assign complete = !stall_if &&
                    ((state_q == S_WAIT && ack_v) ||
                     state_q == S_HOLD);
  assign next_pc  = branch_flag   ? branch_target :
                    redir_valid_q ? redir_pc_q    :
                    pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_buf_d    = inst_buf_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    req_addr_d    = req_addr_q;
    if (state_q == S_WAIT) req_addr_d = pc_q;
    if (flush) begin
      pc_d          = new_pc;
      redir_valid_d = 1'b0;
      if ((state_q == S_WAIT && imem_req && !imem_ack) ||
          (state_q == S_DROP && !imem_ack)) begin
        state_d = S_DROP;
      end else begin
        state_d = S_WAIT;
      end
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_WAIT;
        S_WAIT: begin
          if (!aligned) begin
            state_d = S_ERR;
          end else if (ack_v && stall_if) begin
            state_d    = S_HOLD;
            inst_buf_d = imem_rdata;
          end
        end
        S_DROP: if (imem_ack) state_d = S_WAIT;
        default: ;
      endcase
      if (complete) begin
        pc_d          = next_pc;
        redir_valid_d = 1'b0;
        state_d       = S_WAIT;
      end else if (branch_flag) begin
        // delay slot still in flight; redirect the fetch after it
        redir_valid_d = 1'b1;
        redir_pc_d    = branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inst_buf_q    <= NOP_INST;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      req_addr_q    <= req_addr_d;
    end
  end

endmodule

// File: doc/pc_if.md
# pc_if

Instruction-fetch stage: owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents the fetched pc/instruction pair to the PC→ID pipeline register. It sits directly upstream of the ID pipeline register.
- Honours the pipeline stall vector and exception flush.
- Applies ID-resolved branches after the delay slot.
- Raises a stall request while memory is slow.

## Interface
- RESET_PC, 32'hBFC0_0000, boot fetch address
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  6  pipeline stall vector; bit0 = this stage
  - Rule: stall[1] implies stall[0].
- flush  in  1  exception flush; highest priority
- new_pc  in  32  flush target (exception vector / ERET target)
- branch_flag  in  1  branch taken, resolved in ID
- branch_target  in  32  branch destination
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  read complete; data valid in the same cycle
- imem_rdata  in  32  instruction word
- pc_pc  out  32  pc of the presented instruction
- pc_inst  out  32  presented instruction; 0 (NOP) when nothing valid
- stallreq_if  out  1  stall request to the stall controller
- pc_adel  out  1  misaligned fetch address flag

## Operation
Registers:
- pc
- state: BOOT / WAIT / HOLD / DROP / ERR
- inst_buf
- redir_valid, redir_pc

Reset:
- pc=RESET_PC, state=BOOT, redir_valid=0.

Outputs by state:
- BOOT: imem_req=0, pc_inst=0, stallreq_if=0, pc_adel=0.
- WAIT: imem_req=(pc[1:0]==0), imem_addr=pc.
  - If imem_ack: pc_inst=imem_rdata, stallreq_if=0.
  - Otherwise: pc_inst=0, stallreq_if=1.
- HOLD: imem_req=0, pc_inst=inst_buf, stallreq_if=0.
- DROP: imem_req=1, imem_addr=old pc (held), pc_inst=0, stallreq_if=1.
- ERR: imem_req=0, pc_inst=0, pc_adel=1, stallreq_if=0.
- pc_pc=pc in all states.

Completion, next pc and redirect:
- completion = (WAIT & imem_ack & !stall[0]) | (HOLD & !stall[0]).
- next_pc = branch_flag ? branch_target : redir_valid ? redir_pc : pc+4.
  - pc+4 wraps modulo 2^32.
- On completion: pc<=next_pc, redir_valid<=0, state<=WAIT.
- branch_flag without completion: redir_valid<=1, redir_pc<=branch_target.
  - Re-assertion while ID is held is idempotent.
- Delay slot preserved: the instruction in flight when branch_flag arrives is delivered; the redirect applies to the fetch after it.

Transitions (priority: reset > flush > rest):
- BOOT→WAIT unconditionally.
- WAIT, pc misaligned → ERR; no request is issued.
- WAIT & imem_ack & stall[0] → HOLD, inst_buf<=imem_rdata.
- HOLD stays until !stall[0].
- flush: pc<=new_pc, redir_valid<=0.
  - If state is WAIT with the request outstanding (imem_req & !imem_ack), or already DROP without ack → DROP.
  - Otherwise → WAIT; data acked in this cycle is discarded.
- DROP → WAIT on imem_ack; rdata is discarded. A second flush in DROP just updates pc.
- ERR → WAIT only by flush.

Handshake:
- imem_req, once high, holds with a stable imem_addr until imem_ack.
- Ack may come in the request cycle.
- Ack without req is ignored.
- Reset mid-request abandons it; memory must tolerate this.

## Timing
- Zero-wait memory: one instruction per cycle; pc_inst is combinational from imem_rdata in the ack cycle and captured by the ID register at the following edge.
- N wait cycles: stallreq_if high for N cycles; delivery on cycle N+1.
- Taken branch costs no bubble beyond the delay slot.
- Flush: a new request is issued the cycle after the flush, or after the outstanding ack in DROP.
- All outputs are valid the cycle reset deasserts. BOOT outputs during reset: imem_addr=RESET_PC, pc_pc=RESET_PC, others 0.

## Structure
- Shared package:
  - state enum
  - RESET_PC default
  - NOP_INST=32'h0
  - stall-vector bit index constants
- No sub-modules; a single FSM plus datapath.

## Test plan
- Reset 2 cycles → imem_req=0, pc_pc=BFC00000, pc_inst=0; first request BFC00000 one cycle after release.
- Ack every cycle, rdata=~addr → pc_pc steps +4 per cycle, pc_inst=~pc_pc, stallreq_if never high.
- Ack delayed 3 cycles → stallreq_if=1 for 3 cycles, imem_addr stable, instruction delivered on cycle 4.
- branch_flag (target 0x100) while fetch BFC00008 waits → BFC00008 delivered, next imem_addr=0x100.
- stall[0]=1 during ack → HOLD keeps pc_inst steady; release → next address fetched.
- flush (new_pc 80000180) with request outstanding, ack 2 cycles later → pc_inst=0 throughout, old data dropped, next request 80000180, pending redirect cleared.
- flush to 80000002 → no request, pc_adel=1, pc_inst=0 until the next flush.
